// File: rtl/axil_arbiter_2x1_if.sv
// AXI-Lite bundle shared by the two requester ports and the master port of
// the 2:1 arbiter. The master modport is the side that issues requests.
`timescale 1ns/1ps
interface axil_arbiter_2x1_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH/8
);
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [2:0]            awprot;
  logic                  awvalid;
  logic                  awready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/axil_arbiter_2x1.sv
// Two-requester AXI-Lite arbiter in front of a single master port. Write and
// read paths each run their own round-robin FSM with one transaction in
// flight; all muxing is combinational on the registered grant.
`timescale 1ns/1ps
module axil_arbiter_2x1 #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH/8
) (
  input  logic              clk,
  input  logic              rst,
  axil_arbiter_2x1_if.slave  s0,
  axil_arbiter_2x1_if.slave  s1,
  axil_arbiter_2x1_if.master m
);

  typedef enum logic [1:0] {W_IDLE, W_FWD, W_RESP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_FWD, R_DATA} r_state_e;

  w_state_e w_state_q, w_state_d;
  r_state_e r_state_q, r_state_d;
  logic     w_grant_q, w_grant_d;  // 0 = s0, 1 = s1
  logic     w_last_q,  w_last_d;
  logic     aw_done_q, aw_done_d;
  logic     w_done_q,  w_done_d;
  logic     r_grant_q, r_grant_d;
  logic     r_last_q,  r_last_d;

  // With both requesting, the port that was not served last wins.
  function automatic logic pick_grant(input logic req0, input logic req1, input logic last);
    return (req0 && req1) ? ~last : req1;
  endfunction

  // Write path selection on the registered grant
  logic                  w_fwd, w_resp;
  logic [ADDR_WIDTH-1:0] sel_awaddr;
  logic [2:0]            sel_awprot;
  logic                  sel_awvalid;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [STRB_WIDTH-1:0] sel_wstrb;
  logic                  sel_wvalid, sel_bready;
  logic                  aw_hs, w_hs, b_hs;

  assign w_fwd       = (w_state_q == W_FWD);
  assign w_resp      = (w_state_q == W_RESP);
  assign sel_awaddr  = w_grant_q ? s1.awaddr  : s0.awaddr;
  assign sel_awprot  = w_grant_q ? s1.awprot  : s0.awprot;
  assign sel_awvalid = w_grant_q ? s1.awvalid : s0.awvalid;
  assign sel_wdata   = w_grant_q ? s1.wdata   : s0.wdata;
  assign sel_wstrb   = w_grant_q ? s1.wstrb   : s0.wstrb;
  assign sel_wvalid  = w_grant_q ? s1.wvalid  : s0.wvalid;
  assign sel_bready  = w_grant_q ? s1.bready  : s0.bready;

  // Each channel stops forwarding once its beat has been accepted.
  assign m.awaddr  = w_fwd ? sel_awaddr : '0;
  assign m.awprot  = w_fwd ? sel_awprot : '0;
  assign m.awvalid = w_fwd & sel_awvalid & ~aw_done_q;
  assign m.wdata   = w_fwd ? sel_wdata : '0;
  assign m.wstrb   = w_fwd ? sel_wstrb : '0;
  assign m.wvalid  = w_fwd & sel_wvalid & ~w_done_q;
  assign m.bready  = w_resp & sel_bready;

  assign s0.awready = w_fwd & ~w_grant_q & m.awready & ~aw_done_q;
  assign s1.awready = w_fwd &  w_grant_q & m.awready & ~aw_done_q;
  assign s0.wready  = w_fwd & ~w_grant_q & m.wready & ~w_done_q;
  assign s1.wready  = w_fwd &  w_grant_q & m.wready & ~w_done_q;
  assign s0.bvalid  = w_resp & ~w_grant_q & m.bvalid;
  assign s1.bvalid  = w_resp &  w_grant_q & m.bvalid;
  assign s0.bresp   = (w_resp & ~w_grant_q) ? m.bresp : 2'b00;
  assign s1.bresp   = (w_resp &  w_grant_q) ? m.bresp : 2'b00;

  assign aw_hs = m.awvalid & m.awready;
  assign w_hs  = m.wvalid & m.wready;
  assign b_hs  = m.bvalid & m.bready;

  // Read path selection on the registered grant
  logic                  r_fwd, r_data;
  logic [ADDR_WIDTH-1:0] sel_araddr;
  logic [2:0]            sel_arprot;
  logic                  sel_arvalid, sel_rready;
  logic                  ar_hs, r_hs;

  assign r_fwd       = (r_state_q == R_FWD);
  assign r_data      = (r_state_q == R_DATA);
  assign sel_araddr  = r_grant_q ? s1.araddr  : s0.araddr;
  assign sel_arprot  = r_grant_q ? s1.arprot  : s0.arprot;
  assign sel_arvalid = r_grant_q ? s1.arvalid : s0.arvalid;
  assign sel_rready  = r_grant_q ? s1.rready  : s0.rready;

  assign m.araddr  = r_fwd ? sel_araddr : '0;
  assign m.arprot  = r_fwd ? sel_arprot : '0;
  assign m.arvalid = r_fwd & sel_arvalid;
  assign m.rready  = r_data & sel_rready;

  assign s0.arready = r_fwd & ~r_grant_q & m.arready;
  assign s1.arready = r_fwd &  r_grant_q & m.arready;
  assign s0.rvalid  = r_data & ~r_grant_q & m.rvalid;
  assign s1.rvalid  = r_data &  r_grant_q & m.rvalid;
  assign s0.rdata   = (r_data & ~r_grant_q) ? m.rdata : '0;
  assign s1.rdata   = (r_data &  r_grant_q) ? m.rdata : '0;
  assign s0.rresp   = (r_data & ~r_grant_q) ? m.rresp : 2'b00;
  assign s1.rresp   = (r_data &  r_grant_q) ? m.rresp : 2'b00;

  assign ar_hs = m.arvalid & m.arready;
  assign r_hs  = m.rvalid & m.rready;

  // Write FSM next state: arbitrate, forward AW/W in any order, relay B
  always_comb begin
    w_state_d = w_state_q;
    w_grant_d = w_grant_q;
    w_last_d  = w_last_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    case (w_state_q)
      W_IDLE: begin
        if (s0.awvalid || s1.awvalid) begin
          w_grant_d = pick_grant(s0.awvalid, s1.awvalid, w_last_q);
          w_state_d = W_FWD;
        end
      end
      W_FWD: begin
        if (aw_hs) aw_done_d = 1'b1;
        if (w_hs)  w_done_d  = 1'b1;
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) w_state_d = W_RESP;
      end
      W_RESP: begin
        if (b_hs) begin
          w_last_d  = w_grant_q;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Read FSM next state: arbitrate, forward AR, relay R
  always_comb begin
    r_state_d = r_state_q;
    r_grant_d = r_grant_q;
    r_last_d  = r_last_q;
    case (r_state_q)
      R_IDLE: begin
        if (s0.arvalid || s1.arvalid) begin
          r_grant_d = pick_grant(s0.arvalid, s1.arvalid, r_last_q);
          r_state_d = R_FWD;
        end
      end
      R_FWD:  if (ar_hs) r_state_d = R_DATA;
      R_DATA: begin
        if (r_hs) begin
          r_last_d  = r_grant_q;
          r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // State registers; last pointers reset to s1 so s0 wins first contention
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state_q <= W_IDLE;
      w_grant_q <= 1'b0;
      w_last_q  <= 1'b1;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      r_state_q <= R_IDLE;
      r_grant_q <= 1'b0;
      r_last_q  <= 1'b1;
    end else begin
      w_state_q <= w_state_d;
      w_grant_q <= w_grant_d;
      w_last_q  <= w_last_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      r_state_q <= r_state_d;
      r_grant_q <= r_grant_d;
      r_last_q  <= r_last_d;
    end
  end

endmodule

// File: tb/tb_axil_arbiter_2x1.sv
// Directed bench for the 2:1 AXI-Lite arbiter: two requester drivers, a small
// memory-backed slave on the master side, and hand-computed expectations.
`timescale 1ns/1ps
module tb_axil_arbiter_2x1;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axil_arbiter_2x1_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW)) s0_if ();
  axil_arbiter_2x1_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW)) s1_if ();
  axil_arbiter_2x1_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW)) m_if ();

  axil_arbiter_2x1 #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW)) dut (
    .clk (clk),
    .rst (rst),
    .s0  (s0_if),
    .s1  (s1_if),
    .m   (m_if)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
  endtask

  function automatic logic [31:0] rd_pattern(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, a[15:0]};
  endfunction

  // ---------------- master-side slave model ----------------
  int          awstall_cfg = 0;      // cycles m_awready is held low per AW
  logic [1:0]  bresp_cfg   = 2'b00;
  int          aw_wait = 0;
  logic        aw_got  = 1'b0;
  logic        w_got   = 1'b0;
  logic [31:0] aw_addr_q = '0;
  logic [31:0] w_data_q  = '0;
  logic [3:0]  w_strb_q  = '0;
  logic [31:0] ram [0:255];

  logic m_aw_hs, m_w_hs, m_ar_hs;
  logic [31:0] cur_addr, cur_data;
  logic [3:0]  cur_strb;
  assign m_if.awready = !aw_got && (aw_wait >= awstall_cfg);
  assign m_if.wready  = !w_got;
  assign m_if.arready = !m_if.rvalid;
  assign m_aw_hs  = m_if.awvalid && m_if.awready;
  assign m_w_hs   = m_if.wvalid && m_if.wready;
  assign m_ar_hs  = m_if.arvalid && m_if.arready;
  assign cur_addr = m_aw_hs ? m_if.awaddr : aw_addr_q;
  assign cur_data = m_w_hs ? m_if.wdata : w_data_q;
  assign cur_strb = m_w_hs ? m_if.wstrb : w_strb_q;

  always @(posedge clk) begin
    if (rst) begin
      aw_got <= 1'b0; w_got <= 1'b0; aw_wait <= 0;
      m_if.bvalid <= 1'b0; m_if.bresp <= 2'b00;
      m_if.rvalid <= 1'b0; m_if.rdata <= '0; m_if.rresp <= 2'b00;
    end else begin
      if (m_aw_hs) begin
        aw_got <= 1'b1; aw_addr_q <= m_if.awaddr; aw_wait <= 0;
      end else if (m_if.awvalid) begin
        aw_wait <= aw_wait + 1;
      end
      if (m_w_hs) begin
        w_got <= 1'b1; w_data_q <= m_if.wdata; w_strb_q <= m_if.wstrb;
      end
      if (m_if.bvalid && m_if.bready) begin
        m_if.bvalid <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0;
      end else if (!m_if.bvalid && (aw_got || m_aw_hs) && (w_got || m_w_hs)) begin
        m_if.bvalid <= 1'b1;
        m_if.bresp  <= bresp_cfg;
        for (int b = 0; b < 4; b++)
          if (cur_strb[b]) ram[cur_addr[9:2]][8*b +: 8] <= cur_data[8*b +: 8];
      end
      if (m_ar_hs) begin
        m_if.rvalid <= 1'b1; m_if.rdata <= rd_pattern(m_if.araddr); m_if.rresp <= 2'b00;
      end else if (m_if.rvalid && m_if.rready) begin
        m_if.rvalid <= 1'b0;
      end
    end
  end

  // ---------------- monitors ----------------
  logic [31:0] aw_order [$];
  logic [31:0] ar_order [$];
  int s1_act = 0, s1_wready_cnt = 0, aw_stall_cnt = 0;

  always @(posedge clk) begin
    if (!rst && m_aw_hs) aw_order.push_back(m_if.awaddr);
    if (!rst && m_ar_hs) ar_order.push_back(m_if.araddr);
  end

  always @(negedge clk) begin
    if (s1_if.awready || s1_if.wready || s1_if.bvalid || s1_if.arready || s1_if.rvalid)
      s1_act <= s1_act + 1;
    if (s1_if.wready) s1_wready_cnt <= s1_wready_cnt + 1;
    if (m_if.awvalid && !m_if.awready) aw_stall_cnt <= aw_stall_cnt + 1;
  end

  // ---------------- requester drivers ----------------
  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic set_aw(input int p, input logic v, input logic [31:0] a);
    if (p == 0) begin s0_if.awvalid = v; s0_if.awaddr = a; s0_if.awprot = 3'b000; end
    else        begin s1_if.awvalid = v; s1_if.awaddr = a; s1_if.awprot = 3'b000; end
  endtask
  task automatic set_w(input int p, input logic v, input logic [31:0] d, input logic [3:0] s);
    if (p == 0) begin s0_if.wvalid = v; s0_if.wdata = d; s0_if.wstrb = s; end
    else        begin s1_if.wvalid = v; s1_if.wdata = d; s1_if.wstrb = s; end
  endtask
  task automatic set_ar(input int p, input logic v, input logic [31:0] a);
    if (p == 0) begin s0_if.arvalid = v; s0_if.araddr = a; s0_if.arprot = 3'b000; end
    else        begin s1_if.arvalid = v; s1_if.araddr = a; s1_if.arprot = 3'b000; end
  endtask
  task automatic set_bready(input int p, input logic v);
    if (p == 0) s0_if.bready = v; else s1_if.bready = v;
  endtask
  task automatic set_rready(input int p, input logic v);
    if (p == 0) s0_if.rready = v; else s1_if.rready = v;
  endtask
  task automatic idle_all;
    for (int p = 0; p < 2; p++) begin
      set_aw(p, 1'b0, '0); set_w(p, 1'b0, '0, '0); set_ar(p, 1'b0, '0);
      set_bready(p, 1'b0); set_rready(p, 1'b0);
    end
  endtask

  function automatic logic awready_of(input int p); return (p == 0) ? s0_if.awready : s1_if.awready; endfunction
  function automatic logic wready_of(input int p);  return (p == 0) ? s0_if.wready  : s1_if.wready;  endfunction
  function automatic logic bvalid_of(input int p);  return (p == 0) ? s0_if.bvalid  : s1_if.bvalid;  endfunction
  function automatic logic [1:0] bresp_of(input int p); return (p == 0) ? s0_if.bresp : s1_if.bresp; endfunction
  function automatic logic arready_of(input int p); return (p == 0) ? s0_if.arready : s1_if.arready; endfunction
  function automatic logic rvalid_of(input int p);  return (p == 0) ? s0_if.rvalid  : s1_if.rvalid;  endfunction
  function automatic logic [31:0] rdata_of(input int p); return (p == 0) ? s0_if.rdata : s1_if.rdata; endfunction

  // Full write from requester p; W may lead AW by w_lead cycles, B is
  // accepted after bdelay cycles. ok = 0 when a bounded wait expires.
  task automatic write_txn(input int p, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input int w_lead, input int bdelay,
                           output logic [1:0] resp, output bit ok);
    bit awd, wd, hs_a, hs_w, got;
    int n;
    resp = 2'b11; ok = 1'b0; awd = 1'b0; wd = 1'b0; got = 1'b0; n = 0;
    set_w(p, 1'b1, d, s);
    repeat (w_lead) tick;
    set_aw(p, 1'b1, a);
    while (!(awd && wd) && n < 200) begin
      @(negedge clk);
      hs_a = !awd && awready_of(p);
      hs_w = !wd && wready_of(p);
      @(posedge clk); #1;
      if (hs_a) begin set_aw(p, 1'b0, '0); awd = 1'b1; end
      if (hs_w) begin set_w(p, 1'b0, '0, '0); wd = 1'b1; end
      n++;
    end
    if (awd && wd) begin
      repeat (bdelay) tick;
      set_bready(p, 1'b1);
      n = 0;
      while (!got && n < 200) begin
        @(negedge clk);
        if (bvalid_of(p)) begin resp = bresp_of(p); got = 1'b1; end
        @(posedge clk); #1;
        n++;
      end
      set_bready(p, 1'b0);
    end
    ok = got;
    $display("write s%0d addr=%08h data=%08h strb=%h resp=%0d done=%0d", p, a, d, s, resp, ok);
  endtask

  task automatic read_txn(input int p, input logic [31:0] a, output logic [31:0] d, output bit ok);
    bit ard, got;
    int n;
    d = '0; ard = 1'b0; got = 1'b0; n = 0;
    set_ar(p, 1'b1, a);
    while (!ard && n < 200) begin
      @(negedge clk);
      ard = arready_of(p);
      @(posedge clk); #1;
      n++;
    end
    set_ar(p, 1'b0, '0);
    if (ard) begin
      set_rready(p, 1'b1);
      n = 0;
      while (!got && n < 200) begin
        @(negedge clk);
        if (rvalid_of(p)) begin d = rdata_of(p); got = 1'b1; end
        @(posedge clk); #1;
        n++;
      end
      set_rready(p, 1'b0);
    end
    ok = got;
    $display("read  s%0d addr=%08h data=%08h done=%0d", p, a, d, ok);
  endtask

  task automatic do_reset;
    rst = 1'b1;
    idle_all;
    repeat (2) tick;
    @(negedge clk);
    rst = 1'b0;
    tick;
  endtask

  // Hang guard
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    logic [1:0]  resp, resp_b;
    logic [31:0] rd;
    bit          ok, ok_b;
    int          act0, base, wr0, st0;

    idle_all;
    repeat (3) tick;
    // reset state
    check_eq("rst_m_awvalid", m_if.awvalid, 1'b0);
    check_eq("rst_m_wvalid",  m_if.wvalid,  1'b0);
    check_eq("rst_m_arvalid", m_if.arvalid, 1'b0);
    check_eq("rst_m_awaddr",  m_if.awaddr,  32'h0);
    check_eq("rst_s0_awready", s0_if.awready, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    tick;

    // 1: single write from s0, one-cycle bubble, s1 untouched
    act0 = s1_act;
    fork
      write_txn(0, 32'h1000_0004, 32'hDEAD_BEEF, 4'hF, 0, 0, resp, ok);
      begin
        @(negedge clk);
        check_eq("t1_bubble_awvalid", m_if.awvalid, 1'b0);
        @(negedge clk);
        check_eq("t1_m_awvalid", m_if.awvalid, 1'b1);
        check_eq("t1_m_awaddr",  m_if.awaddr,  32'h1000_0004);
        check_eq("t1_m_wdata",   m_if.wdata,   32'hDEAD_BEEF);
      end
    join
    check_eq("t1_done", ok, 1'b1);
    check_eq("t1_bresp", resp, 2'b00);
    check_eq("t1_ram", ram[1], 32'hDEAD_BEEF);
    check_eq("t1_s1_quiet", s1_act - act0, 0);

    // 2: first contention after reset goes to s0, then s1
    do_reset;
    base = aw_order.size();
    fork
      write_txn(0, 32'h1000_0010, 32'h1111_1111, 4'hF, 0, 0, resp, ok);
      write_txn(1, 32'h1000_0020, 32'h2222_2222, 4'hF, 0, 0, resp_b, ok_b);
    join
    check_eq("t2_done_s0", ok, 1'b1);
    check_eq("t2_done_s1", ok_b, 1'b1);
    check_eq("t2_aw_count", aw_order.size() - base, 2);
    if (aw_order.size() >= base + 2) begin
      check_eq("t2_first_grant",  aw_order[base],     32'h1000_0010);
      check_eq("t2_second_grant", aw_order[base + 1], 32'h1000_0020);
    end
    check_eq("t2_ram_s0", ram[4], 32'h1111_1111);
    check_eq("t2_ram_s1", ram[8], 32'h2222_2222);

    // 3: back-to-back reads from both ports alternate s0,s1,...
    base = ar_order.size();
    fork
      for (int i = 0; i < 4; i++) begin
        logic [31:0] d0; bit k0;
        read_txn(0, 32'h0000_0100 + 32'(4*i), d0, k0);
        check_eq("t3_s0_rdata", d0, rd_pattern(32'h0000_0100 + 32'(4*i)));
      end
      for (int j = 0; j < 4; j++) begin
        logic [31:0] d1; bit k1;
        read_txn(1, 32'h0000_0200 + 32'(4*j), d1, k1);
        check_eq("t3_s1_rdata", d1, rd_pattern(32'h0000_0200 + 32'(4*j)));
      end
    join
    check_eq("t3_ar_count", ar_order.size() - base, 8);
    for (int k = 0; k < 8; k++) begin
      if (ar_order.size() > base + k)
        check_eq("t3_grant_order", ar_order[base + k],
                 ((k % 2) == 0 ? 32'h0000_0100 : 32'h0000_0200) + 32'(4*(k/2)));
    end

    // 4: W leads AW by 3 cycles, m_awready held low 5 cycles
    awstall_cfg = 5;
    wr0 = s1_wready_cnt;
    st0 = aw_stall_cnt;
    write_txn(1, 32'h1000_0030, 32'hCAFE_F00D, 4'hF, 3, 0, resp, ok);
    awstall_cfg = 0;
    check_eq("t4_done", ok, 1'b1);
    check_eq("t4_bresp", resp, 2'b00);
    check_eq("t4_wready_pulses", s1_wready_cnt - wr0, 1);
    check_eq("t4_aw_stall_cycles", aw_stall_cnt - st0, 5);
    check_eq("t4_ram", ram[12], 32'hCAFE_F00D);

    // 5: s0 write (SLVERR, B held off 10 cycles) alongside an s1 read
    bresp_cfg = 2'b10;
    fork
      write_txn(0, 32'h1000_0040, 32'h55AA_55AA, 4'hF, 0, 10, resp, ok);
      begin
        logic [31:0] d5; bit k5;
        read_txn(1, 32'h0000_0300, d5, k5);
        check_eq("t5_read_done", k5, 1'b1);
        check_eq("t5_rdata", d5, rd_pattern(32'h0000_0300));
        check_eq("t5_b_held", {m_if.bvalid, m_if.bready, s0_if.bvalid}, 3'b101);
      end
    join
    bresp_cfg = 2'b00;
    check_eq("t5_write_done", ok, 1'b1);
    check_eq("t5_slverr", resp, 2'b10);
    check_eq("t5_ram", ram[16], 32'h55AA_55AA);

    // 6: reset with AW accepted, W pending and an s1 read in flight
    set_aw(0, 1'b1, 32'h1000_0060);
    set_ar(1, 1'b1, 32'h0000_0400);
    tick;
    tick;
    set_aw(0, 1'b0, '0);
    set_ar(1, 1'b0, '0);
    set_w(0, 1'b1, 32'h1234_5678, 4'hF);
    #1;
    check_eq("t6_pre_wvalid", m_if.wvalid, 1'b1);
    check_eq("t6_pre_s1_rvalid", s1_if.rvalid, 1'b1);
    rst = 1'b1;
    #1;
    check_eq("t6_rst_valids", {m_if.awvalid, m_if.wvalid, m_if.arvalid}, 3'b000);
    check_eq("t6_rst_s1_rvalid", s1_if.rvalid, 1'b0);
    check_eq("t6_rst_s0_wready", s0_if.wready, 1'b0);
    idle_all;
    repeat (2) tick;
    @(negedge clk);
    rst = 1'b0;
    tick;
    write_txn(1, 32'h1000_0050, 32'h0BAD_CAFE, 4'hF, 0, 0, resp, ok);
    check_eq("t6_after_done", ok, 1'b1);
    check_eq("t6_after_bresp", resp, 2'b00);
    check_eq("t6_after_ram", ram[20], 32'h0BAD_CAFE);
    check_eq("t6_no_stale_write", ram[24] === 32'h1234_5678, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
